// File: rtl/pb_operand_loader_pkg.sv
// ---------------------------------------------------------------------------
// pb_operand_loader_pkg
// Shared constants for the pushbutton operand loader: the number of
// operands, the operand width and the default debounce threshold.
// ---------------------------------------------------------------------------
package pb_operand_loader_pkg;

  localparam int NUM_OPERANDS        = 5;
  localparam int OPERAND_W           = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage : pb_operand_loader_pkg

// File: rtl/pb_operand_loader_debounce.sv
// ---------------------------------------------------------------------------
// pb_debounce
// One pushbutton channel: 2-flop synchronizer, debounce counter, debounced
// level and a one-cycle strobe on a debounced 0->1 transition.
//
// Ports
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   pb_i    : raw, asynchronous, bouncing button level (1 = pressed)
//   rise_o  : registered one-cycle strobe, high in the cycle after the
//             debounced level goes 0->1
// ---------------------------------------------------------------------------
module pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_i,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             rise_q,  rise_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Next-state logic: synchronizer shift, counter and level toggle
  always_comb begin
    sync1_d = pb_i;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      // The edge that would take the counter to the threshold is the edge
      // that toggles the level; the counter restarts from zero instead.
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end else begin
      // Level agrees with the debounced value: any partial count is a bounce.
      cnt_d = '0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule : pb_debounce

// File: rtl/pb_operand_loader.sv
// ---------------------------------------------------------------------------
// pb_operand_loader
// Captures a 4-bit switch value into one of five operand registers when the
// matching pushbutton is (debounced) pressed.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   PB1..PB5   : raw pushbutton levels (1 = pressed)
//   Y          : raw switch operand value
//   clr        : synchronous clear of operands and loaded mask
//   X1..X5     : captured operands
//   loaded     : bit i-1 set once Xi captured since reset/clr
//   all_loaded : high when every operand is loaded
//   load_pulse : bit i-1 high for one cycle when Xi is written
// ---------------------------------------------------------------------------
module pb_operand_loader
  import pb_operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    PB1,
  input  logic                    PB2,
  input  logic                    PB3,
  input  logic                    PB4,
  input  logic                    PB5,
  input  logic [OPERAND_W-1:0]    Y,
  input  logic                    clr,
  output logic [OPERAND_W-1:0]    X1,
  output logic [OPERAND_W-1:0]    X2,
  output logic [OPERAND_W-1:0]    X3,
  output logic [OPERAND_W-1:0]    X4,
  output logic [OPERAND_W-1:0]    X5,
  output logic [NUM_OPERANDS-1:0] loaded,
  output logic                    all_loaded,
  output logic [NUM_OPERANDS-1:0] load_pulse
);

  logic [NUM_OPERANDS-1:0] pb_s;
  logic [NUM_OPERANDS-1:0] rise_s;

  logic [OPERAND_W-1:0]    y_s1_q, y_s1_d;
  logic [OPERAND_W-1:0]    y_s2_q, y_s2_d;

  logic [NUM_OPERANDS-1:0][OPERAND_W-1:0] x_q, x_d;
  logic [NUM_OPERANDS-1:0] loaded_q,     loaded_d;
  logic [NUM_OPERANDS-1:0] load_pulse_q, load_pulse_d;
  logic                    all_loaded_q, all_loaded_d;

  assign pb_s = {PB5, PB4, PB3, PB2, PB1};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPERANDS; gi++) begin : g_pb
      pb_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_pb_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .pb_i   (pb_s[gi]),
        .rise_o (rise_s[gi])
      );
    end
  endgenerate

  // Operand capture, clear handling and Y synchronizer next state
  always_comb begin
    y_s1_d       = Y;
    y_s2_d       = y_s1_q;
    x_d          = x_q;
    loaded_d     = loaded_q;
    load_pulse_d = '0;
    if (clr) begin
      // Clear wins over any capture strobe arriving on the same edge.
      x_d      = '0;
      loaded_d = '0;
    end else begin
      for (int i = 0; i < NUM_OPERANDS; i++) begin
        if (rise_s[i]) begin
          x_d[i]          = y_s2_q;
          loaded_d[i]     = 1'b1;
          load_pulse_d[i] = 1'b1;
        end else begin
          x_d[i]          = x_q[i];
        end
      end
    end
    all_loaded_d = &loaded_d;
  end

  // Y synchronizer and operand/status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_s1_q       <= '0;
      y_s2_q       <= '0;
      x_q          <= '0;
      loaded_q     <= '0;
      load_pulse_q <= '0;
      all_loaded_q <= 1'b0;
    end else begin
      y_s1_q       <= y_s1_d;
      y_s2_q       <= y_s2_d;
      x_q          <= x_d;
      loaded_q     <= loaded_d;
      load_pulse_q <= load_pulse_d;
      all_loaded_q <= all_loaded_d;
    end
  end

  assign X1         = x_q[0];
  assign X2         = x_q[1];
  assign X3         = x_q[2];
  assign X4         = x_q[3];
  assign X5         = x_q[4];
  assign loaded     = loaded_q;
  assign load_pulse = load_pulse_q;
  assign all_loaded = all_loaded_q;

endmodule : pb_operand_loader

// File: tb/tb_pb_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_pb_operand_loader
// Directed bench for pb_operand_loader with DEBOUNCE_CYCLES = 4.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_pb_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] pb;
  logic [3:0] y;
  logic       clr;
  logic [3:0] x1, x2, x3, x4, x5;
  logic [4:0] loaded;
  logic       all_loaded;
  logic [4:0] load_pulse;

  int checks = 0;
  int errors = 0;

  pb_operand_loader #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PB1        (pb[0]),
    .PB2        (pb[1]),
    .PB3        (pb[2]),
    .PB4        (pb[3]),
    .PB5        (pb[4]),
    .Y          (y),
    .clr        (clr),
    .X1         (x1),
    .X2         (x2),
    .X3         (x3),
    .X4         (x4),
    .X5         (x5),
    .loaded     (loaded),
    .all_loaded (all_loaded),
    .load_pulse (load_pulse)
  );

  initial forever #5 clk = ~clk;

  // Advance n rising edges, returning on a falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pb    = 5'b00000;
    y     = 4'h0;
    clr   = 1'b0;
    cyc(2);
    chk("rst_x1", x1, 0);
    chk("rst_x5", x5, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_all_loaded", all_loaded, 0);
    chk("rst_load_pulse", load_pulse, 0);
    rst_n = 1'b1;

    // PB1 held, Y = 5: capture at edge 7
    y = 4'h5;
    cyc(3);
    pb[0] = 1'b1;
    cyc(6);
    chk("pb1_edge6_x1", x1, 0);
    chk("pb1_edge6_pulse", load_pulse, 0);
    cyc(1);
    chk("pb1_edge7_x1", x1, 5);
    chk("pb1_edge7_pulse", load_pulse, 5'b00001);
    chk("pb1_edge7_loaded", loaded, 5'b00001);
    chk("pb1_edge7_x2", x2, 0);
    chk("pb1_edge7_all", all_loaded, 0);
    cyc(1);
    chk("pb1_pulse_one_cycle", load_pulse, 0);
    cyc(10);
    chk("pb1_held_no_recapture", load_pulse, 0);
    // Release must not capture the new Y
    y = 4'h9;
    pb[0] = 1'b0;
    cyc(12);
    chk("pb1_release_x1", x1, 5);
    chk("pb1_release_loaded", loaded, 5'b00001);

    // PB2 bouncing 1,0,1,0,... for 8 cycles
    for (int i = 0; i < 8; i++) begin
      pb[1] = (i % 2 == 0);
      cyc(1);
    end
    pb[1] = 1'b0;
    cyc(12);
    chk("bounce_x2", x2, 0);
    chk("bounce_loaded", loaded, 5'b00001);

    // PB3 and PB4 together, Y = 10
    y = 4'hA;
    cyc(3);
    pb[2] = 1'b1;
    pb[3] = 1'b1;
    cyc(7);
    chk("dual_x3", x3, 10);
    chk("dual_x4", x4, 10);
    chk("dual_pulse", load_pulse, 5'b01100);
    chk("dual_loaded", loaded, 5'b01101);
    cyc(1);
    chk("dual_pulse_off", load_pulse, 0);
    pb[2] = 1'b0;
    pb[3] = 1'b0;
    cyc(8);

    // Sequential presses with Y = 15
    y = 4'hF;
    cyc(3);
    for (int i = 0; i < 5; i++) begin
      pb[i] = 1'b1;
      cyc(6);
      if (i == 4) chk("seq_all_before", all_loaded, 0);
      cyc(1);
      chk($sformatf("seq_pulse_%0d", i + 1), load_pulse, 32'(1) << i);
      if (i == 4) chk("seq_all_after", all_loaded, 1);
      pb[i] = 1'b0;
      cyc(8);
    end
    chk("seq_x1", x1, 15);
    chk("seq_x2", x2, 15);
    chk("seq_x3", x3, 15);
    chk("seq_x4", x4, 15);
    chk("seq_x5", x5, 15);
    chk("seq_loaded", loaded, 5'b11111);

    // clr in PB5's capture cycle
    y = 4'h3;
    cyc(3);
    pb[4] = 1'b1;
    cyc(6);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_x5", x5, 0);
    chk("clr_x1", x1, 0);
    chk("clr_loaded", loaded, 0);
    chk("clr_pulse", load_pulse, 0);
    chk("clr_all", all_loaded, 0);
    cyc(20);
    chk("clr_held_x5", x5, 0);
    chk("clr_held_loaded", loaded, 0);
    pb[4] = 1'b0;
    cyc(8);
    pb[4] = 1'b1;
    cyc(7);
    chk("repress_x5", x5, 3);
    chk("repress_loaded", loaded, 5'b10000);
    pb[4] = 1'b0;
    cyc(8);

    // Overwrite of an already loaded operand
    y = 4'h6;
    cyc(3);
    pb[4] = 1'b1;
    cyc(7);
    chk("overwrite_x5", x5, 6);
    chk("overwrite_pulse", load_pulse, 5'b10000);
    chk("overwrite_loaded", loaded, 5'b10000);
    pb[4] = 1'b0;
    cyc(8);

    // Reset pulse mid-debounce with PB1 held
    y = 4'hC;
    cyc(3);
    pb[0] = 1'b1;
    cyc(2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_loaded", loaded, 0);
    chk("async_rst_x5", x5, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    chk("rst_mid_edge6_x1", x1, 0);
    chk("rst_mid_edge6_loaded", loaded, 0);
    cyc(1);
    chk("rst_mid_edge7_x1", x1, 12);
    chk("rst_mid_edge7_pulse", load_pulse, 5'b00001);
    chk("rst_mid_edge7_loaded", loaded, 5'b00001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pb_operand_loader
